mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one external combinational 64x64 multiplier between NUM_REQ requesters.
- Accepts one operand pair at a time with a per-requester valid/ready handshake.
- Drives the multiplier from held operand registers for a programmable multicycle window, then captures the 128-bit product.
- Returns the product with the requester id over a single valid/ready response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 64, operand width; product is 2*WIDTH
- CALC_CYCLES, 1, cycles operands are held on the multiplier before capture (>=1; multicycle-path budget)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request
- req_ready  output  NUM_REQ  one-hot accept strobe
- req_a  input  NUM_REQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH]
- req_b  input  NUM_REQ*WIDTH  operand B, same slicing
- mult_a  output  WIDTH  to multiplier A
- mult_b  output  WIDTH  to multiplier B
- mult_product  input  2*WIDTH  from multiplier product
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_id  output  clog2(NUM_REQ)  index of the requester that owns the result
- resp_product  output  2*WIDTH  captured product
- busy  output  1  high whenever state != IDLE
- op_count  output  32  completed-operation counter

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE, rr_ptr=0, calc_cnt=0.
  - Operand registers, mult_a, mult_b, resp_product, resp_id, op_count all 0.
  - resp_valid=0, req_ready=0, busy=0.
  - rst overrides all other inputs.
  - Reset mid-CALC or mid-RESP aborts the operation; no response is issued.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - grant = first asserted req_valid searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready = onehot(grant), combinational from req_valid and rr_ptr, only in IDLE; all zeros otherwise.
  - On req_valid[g] & req_ready[g] at an edge: latch req_a/req_b slice g into op_a/op_b, latch g into resp_id, set calc_cnt=CALC_CYCLES-1, go to CALC.
  - No valid requests: stay in IDLE.
  - A requester may drop valid before it is granted; arbitration re-evaluates every IDLE cycle.
  - Requesters must hold their operands stable while valid is high.
- CALC:
  - mult_a=op_a and mult_b=op_b, registered and stable for the whole state.
  - If calc_cnt==0: capture mult_product into resp_product, go to RESP. Otherwise decrement calc_cnt.
- RESP:
  - resp_valid=1; resp_product and resp_id are held stable until handshake.
  - On resp_valid & resp_ready: resp_valid=0, rr_ptr=(resp_id+1) mod NUM_REQ, op_count+=1, go to IDLE.
  - Backpressure: stay in RESP indefinitely. New requests are not accepted (req_ready=0).
- Latency: accept at edge k -> resp_valid high after edge k+1+CALC_CYCLES. Minimum occupancy per operation = CALC_CYCLES+2 cycles.
- mult_a/mult_b retain the last operands in IDLE/RESP; they are not cleared.
- op_count wraps 0xFFFFFFFF -> 0 silently.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,...,NUM_REQ-1,0.
- Arithmetic is unsigned; width handling is owned entirely by the external multiplier. The block only transports 2*WIDTH bits.

Test Plan:
- Single op, NUM_REQ=4, CALC_CYCLES=1, external multiplier connected: requester 2 sends A=0x3489BE8F00000000, B=0x00000000FFFFFFFF.
  - req_ready[2] is high in the request cycle.
  - resp_valid rises 2 cycles after acceptance, with resp_id=2 and resp_product=0x000000003489BE8ECB76417100000000.
  - op_count=1 after the response handshake.
- Extreme operands: A=B=0xFFFFFFFFFFFFFFFF -> resp_product=0xFFFFFFFFFFFFFFFE0000000000000001. Also A=0, B=0x123BBBCF00000000 -> 0.
- Contention: all four requesters hold valid with A=i+1, B=10 -> responses in id order 0,1,2,3 with products 10,20,30,40. A second round continues with 0,1,2,3 (rotation from rr_ptr).
- Backpressure: hold resp_ready=0 for 5 cycles.
  - resp_valid, resp_id and resp_product stay constant; all req_ready stay 0 and busy stays 1.
  - Release -> IDLE on the next edge.
- CALC_CYCLES=3: mult_a/mult_b stay constant for exactly 3 CALC cycles; resp_valid rises 4 cycles after acceptance. Swapping mult_product mid-window has no effect before the capture cycle.
- Reset mid-operation: assert rst during CALC.
  - Next cycle: busy=0, resp_valid=0, op_count=0, rr_ptr=0.
  - A subsequent request from requester 3 is granted and completes normally.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sequencer sharing one external multiplier
// Holds one operand pair on the multiplier for a fixed multicycle window and returns the product.
module mult_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 64,
    parameter int CALC_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b,
    output logic [WIDTH-1:0]             mult_a,
    output logic [WIDTH-1:0]             mult_b,
    input  logic [2*WIDTH-1:0]           mult_product,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic [2*WIDTH-1:0]           resp_product,
    output logic                         busy,
    output logic [31:0]                  op_count
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [CW-1:0] CALC_LOAD = CW'(CALC_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t             state, state_next;
    logic [IDW-1:0]     rr_ptr;
    logic [CW-1:0]      calc_cnt;
    logic               loaded;
    logic [WIDTH-1:0]   op_a, op_b;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic [IDW-1:0]     grant;
    logic [IDW-1:0]     idx;
    logic [IDW:0]       sum;
    logic               grant_found;

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

    always_comb begin
        state_next  = state;
        req_ready   = '0;
        grant       = '0;
        grant_found = 1'b0;
        sel_a       = '0;
        sel_b       = '0;
        sum         = '0;
        idx         = '0;
        // Search upward from rr_ptr, wrapping modulo NUM_REQ.
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (sum >= (IDW+1)'(NUM_REQ)) begin
                sum = sum - (IDW+1)'(NUM_REQ);
            end
            idx = sum[IDW-1:0];
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = idx;
                sel_a       = req_a[idx*WIDTH +: WIDTH];
                sel_b       = req_b[idx*WIDTH +: WIDTH];
            end
        end
        case (state)
            IDLE: begin
                if (grant_found && !rst) begin
                    req_ready[grant] = 1'b1;
                    state_next       = CALC;
                end
            end
            CALC: begin
                if (loaded && calc_cnt == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            calc_cnt     <= '0;
            loaded       <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            mult_a       <= '0;
            mult_b       <= '0;
            resp_product <= '0;
            resp_id      <= '0;
            op_count     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_a     <= sel_a;
                        op_b     <= sel_b;
                        resp_id  <= grant;
                        calc_cnt <= CALC_LOAD;
                        loaded   <= 1'b0;
                    end
                end
                CALC: begin
                    // First CALC cycle loads the multiplier; the window counts from then.
                    if (!loaded) begin
                        mult_a <= op_a;
                        mult_b <= op_b;
                        loaded <= 1'b1;
                    end else if (calc_cnt == '0) begin
                        resp_product <= mult_product;
                    end else begin
                        calc_cnt <= calc_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        rr_ptr   <= (resp_id == IDW'(NUM_REQ - 1)) ? '0 : resp_id + 1'b1;
                        op_count <= op_count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - self-checking bench for mult_share_arbiter
// Vector table, hand-written corner sequences and a randomized run against a transaction model.
module tb_mult_share_arbiter;

    logic         clk, rst;
    logic [3:0]   req_valid, req_ready;
    logic [255:0] req_a, req_b;
    logic [63:0]  mult_a, mult_b;
    logic [127:0] mult_product, resp_product;
    logic         resp_valid, resp_ready, busy;
    logic [1:0]   resp_id;
    logic [31:0]  op_count;

    logic [3:0]   req_valid3, req_ready3;
    logic [255:0] req_a3, req_b3;
    logic [63:0]  mult_a3, mult_b3;
    logic [127:0] mult_product3, resp_product3;
    logic         resp_valid3, resp_ready3, busy3, ovr3;
    logic [1:0]   resp_id3;
    logic [31:0]  op_count3;

    int passed = 0;
    int total  = 0;
    int ops_done = 0;

    mult_share_arbiter #(.NUM_REQ(4), .WIDTH(64), .CALC_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mult_a(mult_a), .mult_b(mult_b),
        .mult_product(mult_product), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_product(resp_product), .busy(busy), .op_count(op_count)
    );

    mult_share_arbiter #(.NUM_REQ(4), .WIDTH(64), .CALC_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .mult_a(mult_a3), .mult_b(mult_b3),
        .mult_product(mult_product3), .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_id(resp_id3), .resp_product(resp_product3), .busy(busy3), .op_count(op_count3)
    );

    function automatic logic [127:0] mul(input logic [63:0] a, input logic [63:0] b);
        return {64'd0, a} * {64'd0, b};
    endfunction

    assign mult_product  = mul(mult_a, mult_b);
    assign mult_product3 = ovr3 ? 128'hDEADBEEF_0BAD_F00D_CAFE_1234_5678_9ABC : mul(mult_a3, mult_b3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic run_op(input int id, input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] exp, input string nm);
        int lat;
        @(negedge clk);
        req_a = '0;
        req_b = '0;
        req_a[id*64 +: 64] = a;
        req_b[id*64 +: 64] = b;
        req_valid = 4'b1 << id;
        resp_ready = 1'b0;
        #1 chk({nm, " req_ready"}, 128'(req_ready), 128'(4'b1 << id));
        @(posedge clk); #1;
        req_valid = '0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 128'(lat), 128'd2);
        chk({nm, " resp_id"}, 128'(resp_id), 128'(id));
        chk({nm, " product"}, resp_product, exp);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        ops_done++;
        chk({nm, " idle after resp"}, 128'(busy), 128'd0);
        chk({nm, " op_count"}, 128'(op_count), 128'(ops_done));
    endtask

    typedef struct {
        int           id;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] p;
    } vec_t;
    vec_t vt[6];

    logic [3:0]  rv;
    logic [63:0] ra[4], rb[4];

    function automatic int model_grant(input int rr, input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(rr + k) % 4]) return (rr + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        int n, lat, stable, g, rr_m, m_id, m_resp_at, m_cnt;
        bit m_busy, ok;
        logic [127:0] m_prod;
        logic [1:0] ids[8];
        logic [127:0] prods[8];
        logic [3:0] exp_rdy;

        vt[0] = '{2, 64'h3489BE8F00000000, 64'h00000000FFFFFFFF, 128'h000000003489BE8ECB76417100000000};
        vt[1] = '{0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 128'hFFFFFFFFFFFFFFFE0000000000000001};
        vt[2] = '{3, 64'h0, 64'h123BBBCF00000000, 128'h0};
        vt[3] = '{1, 64'h0000000100000000, 64'h0000000100000000, 128'h00000000000000010000000000000000};
        vt[4] = '{0, 64'h10, 64'h20, 128'h200};
        vt[5] = '{1, 64'h1, 64'hFFFFFFFFFFFFFFFF, 128'h0000000000000000FFFFFFFFFFFFFFFF};

        rst = 1'b1;
        req_valid = 4'hF; req_a = '0; req_b = '0; resp_ready = 1'b0;
        req_valid3 = '0; req_a3 = '0; req_b3 = '0; resp_ready3 = 1'b0; ovr3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 128'(req_ready), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset resp_valid", 128'(resp_valid), 128'd0);
        chk("reset op_count", 128'(op_count), 128'd0);
        chk("reset mult_a", 128'(mult_a), 128'd0);
        chk("reset resp_product", resp_product, 128'd0);
        chk("reset resp_id", 128'(resp_id), 128'd0);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;

        // Contention: all four valid continuously, two full rounds.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            req_a[i*64 +: 64] = 64'(i + 1);
            req_b[i*64 +: 64] = 64'd10;
        end
        req_valid = 4'hF;
        resp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 8; c++) begin
            @(negedge clk); #1;
            if (resp_valid) begin
                ids[n] = resp_id;
                prods[n] = resp_product;
                n++;
            end
        end
        @(negedge clk);
        req_valid = '0;
        resp_ready = 1'b0;
        chk("contention count", 128'(n), 128'd8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("contention id %0d", k), 128'(ids[k]), 128'(k % 4));
            chk($sformatf("contention product %0d", k), prods[k], 128'((k % 4 + 1) * 10));
        end
        ops_done = 8;
        @(posedge clk); #1;
        chk("contention op_count", 128'(op_count), 128'd8);

        for (int v = 0; v < 6; v++) begin
            run_op(vt[v].id, vt[v].a, vt[v].b, vt[v].p, $sformatf("vec%0d", v));
        end

        // Backpressure from requester 1 with the others requesting.
        @(negedge clk);
        req_a = '0; req_b = '0;
        req_a[64 +: 64] = 64'd7;
        req_b[64 +: 64] = 64'd9;
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = 4'hF;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (!(resp_valid && resp_id == 2'd1 && resp_product == 128'd63 && req_ready == 4'd0 && busy))
                ok = 1'b0;
        end
        chk("backpressure hold", 128'(ok), 128'd1);
        chk("backpressure product", resp_product, 128'd63);
        req_valid = '0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        ops_done++;
        chk("backpressure release idle", 128'(busy), 128'd0);
        chk("backpressure op_count", 128'(op_count), 128'(ops_done));

        // CALC_CYCLES=3 window with a corrupted product before the capture cycle.
        @(negedge clk);
        req_a3[63:0] = 64'h0123456789ABCDEF;
        req_b3[63:0] = 64'hFEDCBA9876543210;
        req_valid3 = 4'b0001;
        #1 chk("cc3 req_ready", 128'(req_ready3), 128'd1);
        @(posedge clk); #1;
        req_valid3 = '0;
        ovr3 = 1'b1;
        lat = 0;
        stable = 0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            lat++;
            if (mult_a3 == 64'h0123456789ABCDEF && mult_b3 == 64'hFEDCBA9876543210 && !resp_valid3)
                stable++;
            if (e == 3) ovr3 = 1'b0;
        end
        while (!resp_valid3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("cc3 latency", 128'(lat), 128'd4);
        chk("cc3 operand window", 128'(stable), 128'd3);
        chk("cc3 product", resp_product3, mul(64'h0123456789ABCDEF, 64'hFEDCBA9876543210));
        resp_ready3 = 1'b1;
        @(posedge clk); #1;
        resp_ready3 = 1'b0;
        chk("cc3 mult_a retained", 128'(mult_a3), 128'h0123456789ABCDEF);
        chk("cc3 op_count", 128'(op_count3), 128'd1);

        // Reset in the middle of CALC; rr_ptr is currently 2.
        @(negedge clk);
        req_a[0 +: 64] = 64'd5;
        req_b[0 +: 64] = 64'd6;
        req_valid = 4'b0001;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midreset busy", 128'(busy), 128'd0);
        chk("midreset resp_valid", 128'(resp_valid), 128'd0);
        chk("midreset op_count", 128'(op_count), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'hF;
        #1 chk("midreset rr_ptr", 128'(req_ready), 128'd1);
        req_valid = '0;
        ops_done = 0;
        run_op(3, 64'hAAAA_0000_5555_0000, 64'h3, mul(64'hAAAA_0000_5555_0000, 64'h3), "post-reset");

        // Randomized traffic against the transaction model.
        rr_m = 0; m_busy = 1'b0; m_cnt = 1; m_id = 0; m_resp_at = 0; m_prod = '0;
        rv = '0;
        for (int i = 0; i < 4; i++) begin ra[i] = '0; rb[i] = '0; end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (!rv[i] && $urandom_range(2) == 0) begin
                    rv[i] = 1'b1;
                    ra[i] = {$urandom, $urandom};
                    rb[i] = ($urandom_range(3) == 0) ? 64'hFFFFFFFFFFFFFFFF : {$urandom, $urandom};
                end else if (rv[i] && $urandom_range(7) == 0) begin
                    rv[i] = 1'b0;
                end
                req_a[i*64 +: 64] = ra[i];
                req_b[i*64 +: 64] = rb[i];
            end
            req_valid = rv;
            resp_ready = ($urandom_range(3) != 0);
            #1;
            g = m_busy ? -1 : model_grant(rr_m, rv);
            exp_rdy = (g >= 0) ? (4'b1 << g) : 4'b0;
            chk("rand req_ready", 128'(req_ready), 128'(exp_rdy));
            chk("rand resp_valid", 128'(resp_valid), 128'(m_busy && cyc >= m_resp_at));
            if (m_busy && cyc >= m_resp_at) begin
                chk("rand resp_id", 128'(resp_id), 128'(m_id));
                chk("rand product", resp_product, m_prod);
                if (resp_ready) begin
                    m_busy = 1'b0;
                    rr_m = (m_id + 1) % 4;
                    m_cnt++;
                end
            end
            if (g >= 0) begin
                m_busy = 1'b1;
                m_id = g;
                m_prod = mul(ra[g], rb[g]);
                m_resp_at = cyc + 3;
                rv[g] = 1'b0;
            end
        end
        @(negedge clk);
        req_valid = '0;
        resp_ready = 1'b0;
        #1 chk("rand op_count", 128'(op_count), 128'(m_cnt));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
